credit_tx: RTL and testbench
============================

CREDIT_TX -- requirements
Module: credit_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the payload width in bits.
REQ-002 The block SHALL have parameter MAX_CREDITS, default 4, meaning the receiver buffer depth and the initial credit count.
REQ-003 The block SHALL have parameter CREDIT_WIDTH, default 3, meaning the credit counter width, which must hold MAX_CREDITS.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on posedge clk.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream item is present.
REQ-007 The block SHALL have port in_data, input, DATA_WIDTH bits: the upstream payload.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a registered send strobe to the receiver, with no back-pressure.
REQ-010 The block SHALL have port out_data, output, DATA_WIDTH bits: the registered payload, valid when out_valid=1.
REQ-011 The block SHALL have port credit_ret, input, 1 bit: a one-cycle pulse meaning the receiver freed one buffer slot.
REQ-012 The block SHALL have port credits, output, CREDIT_WIDTH bits: the current credit count.
REQ-013 The block SHALL have port cred_err, output, 1 bit: a sticky flag for a credit_ret received while credits==MAX_CREDITS.

Function
REQ-014 The block SHALL implement a state machine with states INIT, RUN and STALL.
- INIT: the state after reset, held for exactly 1 cycle.
- INIT -> RUN unconditionally.
REQ-015 In RUN, the block SHALL move to STALL when the next credit count is 0.
REQ-016 In STALL, the block SHALL move to RUN when the next credit count is greater than 0.
REQ-017 in_ready SHALL equal 1 only when state==RUN and credits!=0, and SHALL be 0 in INIT and STALL.
REQ-018 An accept SHALL occur on a cycle where in_valid=1 and in_ready=1.
REQ-019 On an accept, the block SHALL set out_valid=1 and out_data=in_data on the next edge, giving 1-cycle latency.
REQ-020 On a cycle with no accept, out_valid SHALL be 0 after the next edge, and out_data SHALL hold its last value.
REQ-021 Credit update per cycle SHALL be:
- accept only: credits-1.
- credit_ret only: credits+1.
- both: unchanged.
- neither: unchanged.
REQ-022 in_ready SHALL be computed from the registered credits only, so a credit_ret arriving while credits==0 does not permit an accept in that cycle; acceptance resumes the following cycle.
REQ-023 credits SHALL never underflow; an accept is impossible at 0 by construction.
REQ-024 On a credit_ret while credits==MAX_CREDITS with no accept, credits SHALL stay at MAX_CREDITS and cred_err SHALL be set.
REQ-025 cred_err SHALL stay set until reset.
REQ-026 A credit_ret during INIT SHALL be ignored for counting and SHALL set cred_err, because credits are already full.
REQ-027 The block SHALL never issue more than MAX_CREDITS outstanding out_valid strobes without an intervening credit_ret.
REQ-028 All arithmetic SHALL be unsigned in CREDIT_WIDTH bits, with no wrap-around permitted.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL apply the following reset values:
- state=INIT.
- credits=MAX_CREDITS.
- out_valid=0.
- out_data=0.
- cred_err=0.
- in_ready=0.
REQ-030 A reset mid-operation SHALL discard outstanding-credit accounting and restore all reset values on the next edge, regardless of in_valid or credit_ret.

Verification
REQ-031 The bench SHALL cover reset then idle: rst high for 2 cycles, then low -> credits=4, in_ready=0 for 1 cycle (INIT), then in_ready=1, out_valid=0.
REQ-032 The bench SHALL cover credit exhaustion: in_valid=1 continuously, data 0xA0..0xA4, no credit_ret -> 4 out_valid strobes carrying 0xA0..0xA3, each 1 cycle after its accept; credits goes 4,3,2,1,0; state STALL; in_ready=0; 0xA4 is held upstream.
REQ-033 The bench SHALL cover resume from stall: from credits=0, a single credit_ret pulse -> credits=1 the next cycle, in_ready=1, 0xA4 accepted, out_valid with 0xA4 one cycle later, credits=0 again.
REQ-034 The bench SHALL cover simultaneous events: credits=2 with accept and credit_ret in the same cycle -> credits stays 2 and out_valid=1 on the next cycle.
REQ-035 The bench SHALL cover over-return: credits=4 with an extra credit_ret pulse -> credits stays 4, cred_err=1 and stays set; a following rst pulse clears it to 0.
REQ-036 The bench SHALL cover mid-operation reset: credits=1 with rst=1 during an accept cycle -> next cycle out_valid=0, credits=4, state INIT.

Source files
------------

// File: rtl/credit_tx.sv
// Credit-based transmitter: forwards upstream items to a receiver with no back-pressure,
// spending one credit per send and regaining one per credit_ret pulse.
module credit_tx #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_CREDITS  = 4,
  parameter int unsigned CREDIT_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    credit_ret,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    cred_err
);

  localparam logic [CREDIT_WIDTH-1:0] MaxCred = CREDIT_WIDTH'(MAX_CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] One     = CREDIT_WIDTH'(1);

  typedef enum logic [1:0] {StInit, StRun, StStall} state_e;

  state_e                  state_q;
  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    out_valid_q;
  logic                    cred_err_q;
  logic                    accept;
  logic                    over_ret;

  // Ready depends only on registered state so a same-cycle credit_ret cannot enable a send.
  always_comb begin
    in_ready  = (state_q == StRun) && (credits_q != '0);
    accept    = in_valid && in_ready;
    credits_d = credits_q;
    over_ret  = 1'b0;
    if (accept && !credit_ret) begin
      credits_d = credits_q - One;
    end else if (credit_ret && !accept) begin
      if (credits_q == MaxCred) begin
        over_ret = 1'b1;
      end else begin
        credits_d = credits_q + One;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      credits_q   <= MaxCred;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cred_err_q  <= 1'b0;
    end else begin
      credits_q   <= credits_d;
      out_valid_q <= accept;
      if (accept) begin
        out_data_q <= in_data;
      end
      if (over_ret) begin
        cred_err_q <= 1'b1;
      end
      case (state_q)
        StInit:  state_q <= StRun;
        StRun:   if (credits_d == '0) state_q <= StStall;
        StStall: if (credits_d != '0) state_q <= StRun;
        default: state_q <= StInit;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign credits   = credits_q;
  assign cred_err  = cred_err_q;

endmodule

// File: tb/tb_credit_tx.sv
// Directed and randomized checks of credit_tx against a credit-accounting model.
module tb_credit_tx;

  localparam int unsigned DW  = 32;
  localparam int unsigned MAX = 4;
  localparam int unsigned CW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          credit_ret;
  logic [CW-1:0] credits;
  logic          cred_err;

  credit_tx #(
    .DATA_WIDTH  (DW),
    .MAX_CREDITS (MAX),
    .CREDIT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .credit_ret(credit_ret),
    .credits   (credits),
    .cred_err  (cred_err)
  );

  always #5 clk = ~clk;

  // Model: outstanding-credit bookkeeping plus a one-cycle "just out of reset" flag.
  int          m_credits;
  bit          m_init;
  bit          m_oval;
  logic [DW-1:0] m_odata;
  bit          m_err;
  bit          last_acc;
  int          n_checks;
  int          n_pass;
  int          n_sent_since_ret;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive inputs at negedge, check outputs, advance the model to the next edge.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit ret, input bit r);
    bit exp_ready;
    @(negedge clk);
    in_valid   = v;
    in_data    = d;
    credit_ret = ret;
    rst        = r;
    #1;
    exp_ready = !m_init && (m_credits > 0);
    chk("in_ready", DW'(in_ready), DW'(exp_ready));
    chk("out_valid", DW'(out_valid), DW'(m_oval));
    if (m_oval) chk("out_data", out_data, m_odata);
    chk("credits", DW'(credits), DW'(m_credits));
    chk("cred_err", DW'(cred_err), DW'(m_err));
    last_acc = v && exp_ready;
    if (r) begin
      m_credits = MAX; m_init = 1; m_oval = 0; m_odata = '0; m_err = 0;
      n_sent_since_ret = 0;
      last_acc = 0;
    end else begin
      m_init = 0;
      m_oval = last_acc;
      if (last_acc) m_odata = d;
      if (last_acc) n_sent_since_ret++;
      if (ret) n_sent_since_ret = 0;
      if (last_acc && !ret) m_credits = m_credits - 1;
      else if (ret && !last_acc) begin
        if (m_credits == MAX) m_err = 1;
        else m_credits = m_credits + 1;
      end
    end
    if (n_sent_since_ret > MAX) begin
      n_checks++;
      $error("FAIL outstanding: observed %0d expected <= %0d", n_sent_since_ret, MAX);
    end
  endtask

  initial begin
    int k;
    n_checks = 0; n_pass = 0; n_sent_since_ret = 0;
    in_valid = 0; in_data = '0; credit_ret = 0; rst = 1;
    @(posedge clk);
    m_credits = MAX; m_init = 1; m_oval = 0; m_odata = '0; m_err = 0;

    // Reset then idle
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);

    // Credit exhaustion: 0xA4 stays upstream
    k = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(1, DW'(32'hA0 + k), 0, 0);
      if (last_acc) k++;
    end
    chk("held_count", DW'(k), DW'(4));

    // Resume from stall with a single credit_ret
    cycle(1, DW'(32'hA4), 1, 0);
    chk("no_acc_on_ret", DW'(last_acc), DW'(0));
    cycle(1, DW'(32'hA4), 0, 0);
    chk("acc_a4", DW'(last_acc), DW'(1));
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);

    // Simultaneous accept and credit_ret at credits=2
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);
    cycle(1, DW'(32'hB0), 1, 0);
    cycle(0, '0, 0, 0);

    // Over-return sets sticky cred_err; reset clears it
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 0);

    // Mid-operation reset during an accept at credits=1
    for (int i = 0; i < 3; i++) cycle(1, DW'(32'hC0 + i), 0, 0);
    cycle(1, DW'(32'hCF), 0, 1);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 60) == 0));
    end
    cycle(0, '0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
